fwrisc_exec_csr_scoreboard: RTL and testbench
=============================================

Name: fwrisc_exec_csr_scoreboard

Overview:
Parametrised successor to the single-instruction exec CSR checker. It is a reusable scoreboard that queues up to DEPTH in-flight CSR instructions captured at decode. It matches register-file writes against the queue head and checks the RD/CSR results at completion. It reports sticky error codes and counters instead of hard asserts, so it serves both formal harnesses and simulation benches around fwrisc_exec.

Parameters:
XLEN, 32, data width of op_a/op_b/rd_wdata
DEPTH, 2, in-flight instruction queue entries (power of 2, >=1)
TIMEOUT, 64, max cycles from head capture to instr_complete; 0 disables
CNT_W, 16, width of checked/error counters

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
decode_valid  in  1  CSR instruction decoded; capture fields this cycle
op  in  6  ALU op (OP_OPA / OP_OR / OP_CLR legal)
op_a  in  XLEN  RS1 value or zero-extended immediate
op_b  in  XLEN  original CSR value
op_c  in  6  CSR register-file address
rd  in  6  destination GPR address (0 = no GPR write)
rd_wen  in  1  register-file write strobe
rd_waddr  in  6  write address
rd_wdata  in  XLEN  write data
instr_complete  in  1  head instruction retires
busy  out  1  queue non-empty
err  out  1  sticky: any error since reset
err_code  out  4  first error code latched (0 = none)
checked_count  out  CNT_W  instructions retired with no error (saturating)
err_count  out  CNT_W  total error events (saturating)

Behaviour:
- Reset: the queue is emptied and every output is 0, including busy, err, err_code and both counters. Reset mid-operation discards all entries.
- Capture: on decode_valid, push {op, op_a, op_b, op_c, rd} and set exp_writes = (rd==0) ? 1 : 2.
  - If decode_valid arrives while the queue is full and instr_complete is not asserted that cycle, the push is dropped with error OVERFLOW(1).
  - Push and pop in the same cycle are legal when full: the pop happens first.
- Expected CSR value by op:
  - OPA: op_a.
  - OR: op_a | op_b.
  - CLR: op_b & ~op_a.
  - Any other op at capture: error ILLEGAL_OP(2); the entry is still queued.
- Write tracking: each head entry has flags gpr_seen and csr_seen.
  - rd_wen while the queue is empty: STRAY_WRITE(3).
  - rd_waddr == head.op_c: compare rd_wdata to the expected CSR value; mismatch gives CSR_DATA(4). If csr_seen is already set, DUP_WRITE(5). Then set csr_seen.
  - rd_waddr == head.rd and rd != 0: compare to head.op_b; mismatch gives RD_DATA(6). If gpr_seen is already set, DUP_WRITE. Then set gpr_seen.
  - When head.rd == head.op_c, one write satisfies both checks.
  - Any other address: BAD_ADDR(7).
- A write in the same cycle as instr_complete counts toward the retiring entry.
- Per-entry states: CAPTURED -> COLLECT (first write seen) -> RETIRED (pop). The head timer runs in CAPTURED and COLLECT and restarts on each pop.
- Retire: on instr_complete with the queue non-empty, the write count must equal exp_writes, otherwise WRITE_COUNT(8).
  - The entry pops regardless of result.
  - checked_count increments if the entry raised no error.
  - instr_complete with an empty queue: SPURIOUS_COMPLETE(9).
- Timeout: when the head timer reaches TIMEOUT, flag TIMEOUT(10) once per entry. The entry stays queued.
- Error reporting:
  - err_code latches only the first error.
  - err_count increments once per cycle in which any error fires.
  - Counters saturate at all-ones.

Optional Feature:
FWRISC_CSR_SB_FORMAL_EN:
- Defined: every error condition is additionally an immediate assert, every legal op and the rd==0 path carry cover statements, and assume(!(decode_valid && full && !instr_complete)) constrains the environment.
- Undefined: no assert, assume or cover is emitted; only the status outputs are produced.

Decomposition:
- Package fwrisc_exec_csr_sb_pkg holds:
  - the err_code enum (values 0..10);
  - a queue-entry struct typedef;
  - the function exp_csr(op, a, b).
- ALU op constants come from the existing alu_op include.
- One sub-module, fwrisc_exec_csr_sb_fifo: a DEPTH-entry sync FIFO with push/pop/full/empty and head peek.

Test Plan:
- CSRRW x5, csr 0x30 mapped to op_c=0x25; op=OPA, op_a=0x1234, op_b=0xAA. Writes: 0x25<=0x1234 and 5<=0xAA, then complete -> checked_count=1, err=0.
- CSRRC with op_a=0x0F, op_b=0xFF -> expected CSR value 0xF0. Driving 0xFF instead -> err_code=4 and err_count=1; the entry still pops and busy=0.
- rd=0 CSRRS with op_a=0x100, op_b=0x1, only the CSR write 0x101 -> passes with exp_writes=1. Adding a write to GPR 0 -> err_code=7.
- DEPTH=2: three back-to-back decode_valid pulses with no complete -> err_code=1 on the third. A later push and pop in the same cycle while full -> no error.
- TIMEOUT=8: decode_valid and no writes for 8 cycles -> err_code=10 at cycle 8, exactly one err_count increment.
- Reset asserted in COLLECT with one write done -> the next cycle shows busy=0 and all outputs 0; the following clean instruction passes.

Source files
------------

// File: rtl/fwrisc_exec_csr_sb_pkg.sv
// =============================================================================
// Module : fwrisc_exec_csr_sb_pkg
// Brief  : Shared types, error codes and expected-value helper for the
//          fwrisc_exec CSR scoreboard.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package fwrisc_exec_csr_sb_pkg;

  // ALU op encodings used by the exec unit for CSR instructions
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_CLR = 6'd4;
  localparam logic [5:0] OP_OPA = 6'd11;

  localparam int SB_XLEN_MAX = 64;

  typedef enum logic [3:0] {
    ERR_NONE              = 4'd0,
    ERR_OVERFLOW          = 4'd1,
    ERR_ILLEGAL_OP        = 4'd2,
    ERR_STRAY_WRITE       = 4'd3,
    ERR_CSR_DATA          = 4'd4,
    ERR_DUP_WRITE         = 4'd5,
    ERR_RD_DATA           = 4'd6,
    ERR_BAD_ADDR          = 4'd7,
    ERR_WRITE_COUNT       = 4'd8,
    ERR_SPURIOUS_COMPLETE = 4'd9,
    ERR_TIMEOUT           = 4'd10
  } csr_sb_err_e;

  // Non-data fields of a queued instruction; operand values travel alongside
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] op_c;
    logic [5:0] rd;
    logic       illegal;
  } csr_sb_meta_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_OPA) || (op == OP_OR) || (op == OP_CLR);
  endfunction

  function automatic logic [SB_XLEN_MAX-1:0] exp_csr(
    input logic [5:0]             op,
    input logic [SB_XLEN_MAX-1:0] a,
    input logic [SB_XLEN_MAX-1:0] b
  );
    case (op)
      OP_OPA:  return a;
      OP_OR:   return a | b;
      OP_CLR:  return b & ~a;
      default: return '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwrisc_exec_csr_sb_fifo.sv
// =============================================================================
// Module : fwrisc_exec_csr_sb_fifo
// Brief  : DEPTH-entry synchronous FIFO with head peek; pop-before-push when full.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module fwrisc_exec_csr_sb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwrisc_exec_csr_scoreboard.sv
// =============================================================================
// Module : fwrisc_exec_csr_scoreboard
// Brief  : Queues in-flight CSR instructions and checks their register-file
//          writes, reporting sticky error codes and counters.
//          Optional FWRISC_CSR_SB_FORMAL_EN adds assert/assume/cover properties.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module fwrisc_exec_csr_scoreboard
  import fwrisc_exec_csr_sb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             decode_valid,
  input  logic [5:0]       op,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [5:0]       op_c,
  input  logic [5:0]       rd,
  input  logic             rd_wen,
  input  logic [5:0]       rd_waddr,
  input  logic [XLEN-1:0]  rd_wdata,
  input  logic             instr_complete,
  output logic             busy,
  output logic             err,
  output logic [3:0]       err_code,
  output logic [CNT_W-1:0] checked_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int EW = $bits(csr_sb_meta_t) + 2 * XLEN;

  typedef enum logic [0:0] { ST_CAPTURED = 1'b0, ST_COLLECT = 1'b1 } head_state_e;

  csr_sb_meta_t    push_meta;
  csr_sb_meta_t    head_meta;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head_data;
  logic [XLEN-1:0] head_a;
  logic [XLEN-1:0] head_b;
  logic [XLEN-1:0] head_exp;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push_ok;
  logic            head_change;

  head_state_e     state;
  logic            csr_seen;
  logic            gpr_seen;
  logic            head_err;
  logic            timed_out;
  logic [31:0]     timer;

  logic [10:1]     err_vec;
  logic [3:0]      code_now;
  logic            csr_hit;
  logic            gpr_hit;
  logic            csr_nx;
  logic            gpr_nx;
  logic            entry_err_now;
  logic            timeout_fire;
  logic [1:0]      exp_writes;

  assign pop         = instr_complete && !empty;
  assign push_ok     = decode_valid && (!full || pop);
  assign head_change = pop || (push_ok && empty);
  assign push_meta   = '{op: op, op_c: op_c, rd: rd, illegal: !op_legal(op)};
  assign push_data   = {push_meta, op_a, op_b};
  assign {head_meta, head_a, head_b} = head_data;
  assign head_exp    = XLEN'(exp_csr(head_meta.op, 64'(head_a), 64'(head_b)));
  assign exp_writes  = (head_meta.rd == 6'd0) ? 2'd1 : 2'd2;
  assign timeout_fire = (TIMEOUT != 0) && !empty && !timed_out && (timer == 32'(TIMEOUT - 1));

  fwrisc_exec_csr_sb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_ok),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head_data)
  );

  always_comb begin
    err_vec       = '0;
    csr_hit       = 1'b0;
    gpr_hit       = 1'b0;
    // seen flags only carry meaning once the head has collected a write
    csr_nx        = (state == ST_COLLECT) && csr_seen;
    gpr_nx        = (state == ST_COLLECT) && gpr_seen;
    code_now      = ERR_NONE;
    entry_err_now = 1'b0;

    if (decode_valid && full && !instr_complete) err_vec[ERR_OVERFLOW] = 1'b1;
    if (push_ok && push_meta.illegal)            err_vec[ERR_ILLEGAL_OP] = 1'b1;

    if (rd_wen) begin
      if (empty) begin
        err_vec[ERR_STRAY_WRITE] = 1'b1;
      end else begin
        csr_hit = (rd_waddr == head_meta.op_c);
        gpr_hit = (rd_waddr == head_meta.rd) && (head_meta.rd != 6'd0);
        if (csr_hit) begin
          if (rd_wdata != head_exp) err_vec[ERR_CSR_DATA]  = 1'b1;
          if (csr_nx)               err_vec[ERR_DUP_WRITE] = 1'b1;
          csr_nx = 1'b1;
        end
        if (gpr_hit) begin
          if (rd_wdata != head_b)   err_vec[ERR_RD_DATA]   = 1'b1;
          if (gpr_nx)               err_vec[ERR_DUP_WRITE] = 1'b1;
          gpr_nx = 1'b1;
        end
        if (!csr_hit && !gpr_hit)   err_vec[ERR_BAD_ADDR]  = 1'b1;
      end
    end

    if (timeout_fire) err_vec[ERR_TIMEOUT] = 1'b1;

    if (instr_complete) begin
      if (empty) err_vec[ERR_SPURIOUS_COMPLETE] = 1'b1;
      else if (({1'b0, csr_nx} + {1'b0, gpr_nx}) != exp_writes) err_vec[ERR_WRITE_COUNT] = 1'b1;
    end

    entry_err_now = (|err_vec[8:4]) || err_vec[ERR_TIMEOUT];

    // descending scan leaves the lowest-numbered simultaneous error
    for (int k = 10; k >= 1; k--) begin
      if (err_vec[k]) code_now = 4'(k);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_CAPTURED;
      csr_seen      <= 1'b0;
      gpr_seen      <= 1'b0;
      head_err      <= 1'b0;
      timed_out     <= 1'b0;
      timer         <= '0;
      err_code      <= ERR_NONE;
      err_count     <= '0;
      checked_count <= '0;
    end else begin
      if (head_change) begin
        state     <= ST_CAPTURED;
        csr_seen  <= 1'b0;
        gpr_seen  <= 1'b0;
        head_err  <= 1'b0;
        timed_out <= 1'b0;
        timer     <= '0;
      end else if (!empty) begin
        state     <= (csr_nx || gpr_nx) ? ST_COLLECT : ST_CAPTURED;
        csr_seen  <= csr_nx;
        gpr_seen  <= gpr_nx;
        head_err  <= head_err || entry_err_now;
        if (timeout_fire) timed_out <= 1'b1;
        if (timer != 32'(TIMEOUT)) timer <= timer + 1'b1;
      end

      if (|err_vec) begin
        if (err_count != '1)       err_count <= err_count + 1'b1;
        if (err_code == ERR_NONE)  err_code  <= code_now;
      end

      if (pop && !(head_err || head_meta.illegal || entry_err_now) && (checked_count != '1))
        checked_count <= checked_count + 1'b1;
    end
  end

  assign busy = !empty;
  assign err  = (err_code != ERR_NONE);

`ifdef FWRISC_CSR_SB_FORMAL_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      assume (!(decode_valid && full && !instr_complete));
      for (int k = 1; k <= 10; k++) begin
        assert (!err_vec[k]);
      end
      cover (push_ok && op == OP_OPA);
      cover (push_ok && op == OP_OR);
      cover (push_ok && op == OP_CLR);
      cover (push_ok && rd == 6'd0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_exec_csr_scoreboard.sv
// =============================================================================
// Module : tb_fwrisc_exec_csr_scoreboard
// Brief  : Directed and randomized bench against a queue-based reference model.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_fwrisc_exec_csr_scoreboard;
  import fwrisc_exec_csr_sb_pkg::*;

  localparam int XLEN = 32, DEPTH = 2, TIMEOUT = 8, CNT_W = 16;

  logic clock = 1'b0;
  logic reset, decode_valid, rd_wen, instr_complete;
  logic [5:0] op, op_c, rd, rd_waddr;
  logic [XLEN-1:0] op_a, op_b, rd_wdata;
  logic busy, err;
  logic [3:0] err_code;
  logic [CNT_W-1:0] checked_count, err_count;

  fwrisc_exec_csr_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .op(op), .op_a(op_a),
    .op_b(op_b), .op_c(op_c), .rd(rd), .rd_wen(rd_wen), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .instr_complete(instr_complete), .busy(busy), .err(err),
    .err_code(err_code), .checked_count(checked_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] op, c, rd;
    logic [31:0] a, b;
    bit cs, gs, bad, timed;
    int age;
  } ent_t;

  ent_t q[$];
  int   m_checked, m_errcnt, m_code;
  int   vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_csr(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o == OP_OPA) return a;
    if (o == OP_OR)  return a | b;
    if (o == OP_CLR) return b & ~a;
    return 32'h0;
  endfunction

  task automatic model_step();
    bit [10:0] e = '0;
    bit had = (q.size() != 0);
    bit popped = 1'b0;
    if (reset) begin
      q.delete(); m_checked = 0; m_errcnt = 0; m_code = 0;
      return;
    end
    if (decode_valid && q.size() == DEPTH && !instr_complete) e[1] = 1;
    if (rd_wen) begin
      if (!had) e[3] = 1;
      else begin
        bit hit = 0;
        if (rd_waddr == q[0].c) begin
          hit = 1;
          if (rd_wdata != ref_csr(q[0].op, q[0].a, q[0].b)) e[4] = 1;
          if (q[0].cs) e[5] = 1;
          q[0].cs = 1;
        end
        if (rd_waddr == q[0].rd && q[0].rd != 0) begin
          hit = 1;
          if (rd_wdata != q[0].b) e[6] = 1;
          if (q[0].gs) e[5] = 1;
          q[0].gs = 1;
        end
        if (!hit) e[7] = 1;
      end
    end
    if (had && !q[0].timed && q[0].age == TIMEOUT - 1) begin
      e[10] = 1; q[0].timed = 1;
    end
    if (instr_complete) begin
      if (!had) e[9] = 1;
      else begin
        if (int'(q[0].cs) + int'(q[0].gs) != ((q[0].rd == 0) ? 1 : 2)) e[8] = 1;
        if (!(q[0].bad || e[4] || e[5] || e[6] || e[7] || e[8] || e[10]))
          m_checked = (m_checked < 65535) ? m_checked + 1 : m_checked;
        void'(q.pop_front());
        popped = 1;
      end
    end else if (had) begin
      q[0].bad = q[0].bad || e[4] || e[5] || e[6] || e[7] || e[10];
    end
    if (decode_valid && q.size() < DEPTH) begin
      ent_t n;
      n.op = op; n.c = op_c; n.rd = rd; n.a = op_a; n.b = op_b;
      n.cs = 0; n.gs = 0; n.timed = 0; n.age = 0;
      n.bad = !(op == OP_OPA || op == OP_OR || op == OP_CLR);
      if (n.bad) e[2] = 1;
      q.push_back(n);
    end
    if (had && !popped) q[0].age++;
    if (e != 0) begin
      if (m_errcnt < 65535) m_errcnt++;
      if (m_code == 0) for (int k = 10; k >= 1; k--) if (e[k]) m_code = k;
    end
  endtask

  task automatic idle();
    reset = 0; decode_valid = 0; op = 0; op_a = 0; op_b = 0; op_c = 0; rd = 0;
    rd_wen = 0; rd_waddr = 0; rd_wdata = 0; instr_complete = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("busy", busy, (q.size() != 0));
    check("err", err, (m_code != 0));
    check("err_code", err_code, m_code);
    check("checked_count", checked_count, m_checked);
    check("err_count", err_count, m_errcnt);
    idle();
  endtask

  task automatic dec(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [5:0] c, input logic [5:0] r);
    decode_valid = 1; op = o; op_a = a; op_b = b; op_c = c; rd = r;
  endtask

  task automatic wr(input logic [5:0] adr, input logic [31:0] d);
    rd_wen = 1; rd_waddr = adr; rd_wdata = d;
  endtask

  task automatic do_reset();
    reset = 1; tick();
  endtask

  initial begin
    idle();
    reset = 1; tick();
    reset = 1; tick();
    check("rst_busy", busy, 0); check("rst_code", err_code, 0);
    check("rst_cnt", checked_count, 0); check("rst_errcnt", err_count, 0);

    // CSRRW x5 with GPR and CSR writes
    dec(OP_OPA, 32'h1234, 32'hAA, 6'h25, 6'd5); tick();
    wr(6'h25, 32'h1234); tick();
    wr(6'd5, 32'hAA); tick();
    instr_complete = 1; tick();
    check("t1_checked", checked_count, 1); check("t1_err", err, 0);

    // CSRRC with wrong CSR data
    dec(OP_CLR, 32'h0F, 32'hFF, 6'h10, 6'd6); tick();
    wr(6'h10, 32'hFF); tick();
    wr(6'd6, 32'hFF); tick();
    instr_complete = 1; tick();
    check("t2_code", err_code, 4); check("t2_errcnt", err_count, 1); check("t2_busy", busy, 0);

    // rd=0 CSRRS, then stray GPR0 write
    do_reset();
    dec(OP_OR, 32'h100, 32'h1, 6'h11, 6'd0); tick();
    wr(6'h11, 32'h101); tick();
    instr_complete = 1; tick();
    check("t3_checked", checked_count, 1); check("t3_err", err, 0);
    dec(OP_OR, 32'h100, 32'h1, 6'h11, 6'd0); tick();
    wr(6'h11, 32'h101); tick();
    wr(6'd0, 32'h5); tick();
    instr_complete = 1; tick();
    check("t3_code", err_code, 7);

    // Overflow, then legal push+pop while full
    do_reset();
    for (int i = 0; i < 3; i++) begin dec(OP_OPA, 32'h5, 32'h0, 6'h20, 6'd0); tick(); end
    check("t4_code", err_code, 1); check("t4_busy", busy, 1);
    dec(OP_OPA, 32'h5, 32'h0, 6'h20, 6'd0); wr(6'h20, 32'h5); instr_complete = 1; tick();
    check("t4_errcnt", err_count, 1); check("t4_checked", checked_count, 1);
    for (int i = 0; i < 2; i++) begin wr(6'h20, 32'h5); instr_complete = 1; tick(); end
    check("t4_drain", checked_count, 3);

    // Timeout after 8 resident cycles
    do_reset();
    dec(OP_OPA, 32'h1, 32'h2, 6'h21, 6'd3); tick();
    for (int i = 0; i < 7; i++) tick();
    check("t5_pre", err_code, 0);
    tick();
    check("t5_code", err_code, 10); check("t5_errcnt", err_count, 1);
    for (int i = 0; i < 5; i++) tick();
    check("t5_once", err_count, 1);

    // Reset in COLLECT
    do_reset();
    dec(OP_OPA, 32'h7, 32'h9, 6'h22, 6'd4); tick();
    wr(6'h22, 32'h7); tick();
    do_reset();
    check("t6_busy", busy, 0); check("t6_code", err_code, 0); check("t6_cnt", checked_count, 0);
    dec(OP_OPA, 32'h7, 32'h9, 6'h22, 6'd4); tick();
    wr(6'h22, 32'h7); tick();
    wr(6'd4, 32'h9); instr_complete = 1; tick();
    check("t6_checked", checked_count, 1); check("t6_err", err, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) reset = 1;
      if ($urandom_range(3) == 0) begin
        logic [5:0] o;
        case ($urandom_range(9))
          0: o = 6'($urandom);
          1, 2, 3: o = OP_OPA;
          4, 5, 6: o = OP_OR;
          default: o = OP_CLR;
        endcase
        dec(o, $urandom_range(255), $urandom_range(255), 6'h20 + 6'($urandom_range(3)),
            ($urandom_range(2) == 0) ? 6'd0 : 6'($urandom_range(31)));
      end
      if ($urandom_range(2) == 0) begin
        if (q.size() != 0 && $urandom_range(9) != 0) begin
          if ($urandom_range(1) == 0 || q[0].rd == 0)
            wr(q[0].c, ($urandom_range(9) == 0) ? 32'hDEAD : ref_csr(q[0].op, q[0].a, q[0].b));
          else
            wr(q[0].rd, ($urandom_range(9) == 0) ? 32'hBEEF : q[0].b);
        end else begin
          wr(6'($urandom), 32'($urandom));
        end
      end
      if ($urandom_range(4) == 0) instr_complete = 1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
